// File: rtl/clock_div_pkg.sv
// Shared constants and capture-time clamping helpers for the programmable clock divider.
package clock_div_pkg;

   localparam int MIN_DIV = 2;

   // Divisor below MIN_DIV is raised to MIN_DIV.
   function automatic logic [31:0] clamp_div(input logic [31:0] d);
      return (d < 32'(MIN_DIV)) ? 32'(MIN_DIV) : d;
   endfunction

   // High time is limited to [1, div-1], where div is the already-clamped divisor.
   function automatic logic [31:0] clamp_high(input logic [31:0] h, input logic [31:0] d_clamped);
      if (h == 32'd0)
         return 32'd1;
      else if (h > d_clamped - 32'd1)
         return d_clamped - 32'd1;
      else
         return h;
   endfunction

endpackage

// File: rtl/prog_clock_div_channel.sv
// One divider channel: period counter, shadowed div/high settings, pending flag, registered outputs.
module prog_clock_div_channel
   import clock_div_pkg::*;
#(
   parameter int WIDTH        = 16,
   parameter int DEFAULT_DIV  = 10,
   parameter int DEFAULT_HIGH = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] div_in,
   input  logic [WIDTH-1:0] high_in,
   output logic             clk_out,
   output logic             tick,
   output logic             pending
);

   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] HIGH_RST = WIDTH'(DEFAULT_HIGH);

   logic [WIDTH-1:0] act_div, act_high;
   logic [WIDTH-1:0] sh_div, sh_high;
   logic [WIDTH-1:0] cnt;
   logic             run;

   logic [WIDTH-1:0] ld_div, ld_high;
   logic [WIDTH-1:0] next_div, next_high, next_cnt;
   logic             wrap, apply;

   always_comb begin
      ld_div  = WIDTH'(clamp_div(32'(div_in)));
      ld_high = WIDTH'(clamp_high(32'(high_in), 32'(ld_div)));

      // run marks a period already in progress, so the first enabled edge always restarts at 0.
      wrap  = run && (cnt == act_div - ONE);
      apply = pending && (!en || wrap);

      next_div  = apply ? sh_div  : act_div;
      next_high = apply ? sh_high : act_high;
      next_cnt  = (!en || !run || wrap) ? '0 : cnt + ONE;
   end

   // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         act_div  <= DIV_RST;
         act_high <= HIGH_RST;
         sh_div   <= DIV_RST;
         sh_high  <= HIGH_RST;
         cnt      <= '0;
         run      <= 1'b0;
         pending  <= 1'b0;
         clk_out  <= 1'b0;
         tick     <= 1'b0;
      end else begin
         act_div  <= next_div;
         act_high <= next_high;
         // A load on the apply edge is captured after the older shadow has been consumed.
         if (load) begin
            sh_div  <= ld_div;
            sh_high <= ld_high;
            pending <= 1'b1;
         end else if (apply) begin
            pending <= 1'b0;
         end
         run     <= en;
         cnt     <= next_cnt;
         clk_out <= en && (next_cnt < next_high);
         tick    <= en && (next_cnt == '0);
      end
   end

endmodule

// File: rtl/prog_clock_div.sv
// Multi-channel programmable clock-enable generator; one independent channel per slice of the packed buses.
module prog_clock_div
   import clock_div_pkg::*;
#(
   parameter int CHANNELS     = 2,
   parameter int WIDTH        = 16,
   parameter int DEFAULT_DIV  = 10,
   parameter int DEFAULT_HIGH = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS-1:0]       en,
   input  logic [CHANNELS-1:0]       load,
   input  logic [CHANNELS*WIDTH-1:0] div_in,
   input  logic [CHANNELS*WIDTH-1:0] high_in,
   output logic [CHANNELS-1:0]       clk_out,
   output logic [CHANNELS-1:0]       tick,
   output logic [CHANNELS-1:0]       pending
);

   for (genvar i = 0; i < CHANNELS; i++) begin : gen_ch
      prog_clock_div_channel #(
         .WIDTH        (WIDTH),
         .DEFAULT_DIV  (DEFAULT_DIV),
         .DEFAULT_HIGH (DEFAULT_HIGH)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .en      (en[i]),
         .load    (load[i]),
         .div_in  (div_in[i*WIDTH +: WIDTH]),
         .high_in (high_in[i*WIDTH +: WIDTH]),
         .clk_out (clk_out[i]),
         .tick    (tick[i]),
         .pending (pending[i])
      );
   end

endmodule

// File: tb/tb_prog_clock_div.sv
// Self-checking bench for prog_clock_div: directed scenarios plus randomized run against a period-level model.
module tb_prog_clock_div;

   localparam int CH = 2;
   localparam int W  = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [CH-1:0]     en = '0;
   logic [CH-1:0]     load = '0;
   logic [CH*W-1:0]   div_in = '0;
   logic [CH*W-1:0]   high_in = '0;
   logic [CH-1:0]     clk_out, tick, pending;

   int errors = 0;
   int checks = 0;

   prog_clock_div #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(10), .DEFAULT_HIGH(5)) dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .load    (load),
      .div_in  (div_in),
      .high_in (high_in),
      .clk_out (clk_out),
      .tick    (tick),
      .pending (pending)
   );

   always #5 clk = ~clk;

   // Reference model: phase within the current period (-1 = idle), active and queued settings.
   int m_div[CH], m_high[CH], m_sdiv[CH], m_shigh[CH], m_ph[CH];
   bit m_pend[CH], m_clk[CH], m_tick[CH];

   bit cap_clk[CH][64], cap_tick[CH][64], cap_pend[CH][64];

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_div[c] = 10; m_high[c] = 5; m_sdiv[c] = 10; m_shigh[c] = 5;
         m_ph[c] = -1; m_pend[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
      end
   endtask

   task automatic model_edge();
      if (reset) begin
         model_reset();
         return;
      end
      for (int c = 0; c < CH; c++) begin
         bit take;
         int d, h;
         take = 0;
         if (!en[c]) begin
            m_ph[c] = -1;
            take = m_pend[c];
         end else if (m_ph[c] < 0) begin
            m_ph[c] = 0;
         end else if (m_ph[c] == m_div[c] - 1) begin
            m_ph[c] = 0;
            take = m_pend[c];
         end else begin
            m_ph[c]++;
         end
         if (take) begin
            m_div[c] = m_sdiv[c];
            m_high[c] = m_shigh[c];
         end
         if (load[c]) begin
            d = int'(div_in[c*W +: W]);
            h = int'(high_in[c*W +: W]);
            d = (d < 2) ? 2 : d;
            h = (h < 1) ? 1 : ((h > d - 1) ? d - 1 : h);
            m_sdiv[c] = d; m_shigh[c] = h; m_pend[c] = 1;
         end else if (take) begin
            m_pend[c] = 0;
         end
         m_clk[c]  = (m_ph[c] >= 0) && (m_ph[c] < m_high[c]);
         m_tick[c] = (m_ph[c] == 0);
      end
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         model_edge();
         @(posedge clk);
         #1;
      end
   endtask

   // Samples the current cycle, then advances; leaves the bench at cycle index n.
   task automatic capture(input int n);
      for (int i = 0; i < n; i++) begin
         for (int c = 0; c < CH; c++) begin
            cap_clk[c][i] = clk_out[c];
            cap_tick[c][i] = tick[c];
            cap_pend[c][i] = pending[c];
         end
         step();
      end
   endtask

   task automatic set_cfg(input int c, input int d, input int h);
      div_in[c*W +: W]  = W'(d);
      high_in[c*W +: W] = W'(h);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(2);
      checks++;
      if (clk_out !== '0) begin errors++; $display("FAIL reset_clk_out got=%b want=00", clk_out); end
      checks++;
      if (tick !== '0) begin errors++; $display("FAIL reset_tick got=%b want=00", tick); end
      checks++;
      if (pending !== '0) begin errors++; $display("FAIL reset_pending got=%b want=00", pending); end
      reset = 1'b0;
   endtask

   task automatic test_defaults();
      en[0] = 1'b1;
      step();
      capture(20);
      for (int k = 0; k < 20; k++) begin
         checks++;
         if (cap_clk[0][k] !== ((k % 10) < 5)) begin
            errors++; $display("FAIL defaults_clk cyc=%0d got=%b want=%b", k, cap_clk[0][k], (k % 10) < 5);
         end
         checks++;
         if (cap_tick[0][k] !== ((k % 10) == 0)) begin
            errors++; $display("FAIL defaults_tick cyc=%0d got=%b want=%b", k, cap_tick[0][k], (k % 10) == 0);
         end
      end
      checks++;
      if (clk_out[1] !== 1'b0) begin errors++; $display("FAIL defaults_ch1_idle got=%b want=0", clk_out[1]); end
      en[0] = 1'b0;
      step();
   endtask

   task automatic test_boundary_apply();
      int n, hi;
      en[0] = 1'b1;
      step(3);
      set_cfg(0, 4, 1);
      load[0] = 1'b1;
      step();
      load[0] = 1'b0;
      n = 0; hi = 0;
      while (pending[0] && n < 30) begin
         n++;
         hi += int'(clk_out[0]);
         step();
      end
      checks++;
      if (n != 7) begin errors++; $display("FAIL boundary_pending_len got=%0d want=7", n); end
      checks++;
      if (hi != 2) begin errors++; $display("FAIL boundary_old_high got=%0d want=2", hi); end
      capture(8);
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (cap_clk[0][k] !== ((k % 4) < 1) || cap_tick[0][k] !== ((k % 4) == 0)) begin
            errors++; $display("FAIL boundary_new_period cyc=%0d got=%b/%b want=%b/%b", k,
                               cap_clk[0][k], cap_tick[0][k], (k % 4) < 1, (k % 4) == 0);
         end
      end
      en[0] = 1'b0;
      step();
   endtask

   task automatic test_clamping();
      set_cfg(0, 0, 0);
      load[0] = 1'b1; step(); load[0] = 1'b0; step();
      en[0] = 1'b1; step();
      capture(6);
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (cap_clk[0][k] !== ((k % 2) < 1)) begin
            errors++; $display("FAIL clamp_low cyc=%0d got=%b want=%b", k, cap_clk[0][k], (k % 2) < 1);
         end
      end
      en[0] = 1'b0; step();
      set_cfg(0, 6, 9);
      load[0] = 1'b1; step(); load[0] = 1'b0; step();
      en[0] = 1'b1; step();
      capture(12);
      for (int k = 0; k < 12; k++) begin
         checks++;
         if (cap_clk[0][k] !== ((k % 6) < 5)) begin
            errors++; $display("FAIL clamp_high cyc=%0d got=%b want=%b", k, cap_clk[0][k], (k % 6) < 5);
         end
      end
      en[0] = 1'b0; step();
   endtask

   task automatic test_disable_reload();
      en[0] = 1'b1;
      step(3);
      en[0] = 1'b0;
      step();
      checks++;
      if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
         errors++; $display("FAIL disable_outputs got=%b/%b want=0/0", clk_out[0], tick[0]);
      end
      set_cfg(0, 3, 2);
      load[0] = 1'b1; step(); load[0] = 1'b0;
      checks++;
      if (pending[0] !== 1'b1) begin errors++; $display("FAIL disable_pending_set got=%b want=1", pending[0]); end
      step();
      checks++;
      if (pending[0] !== 1'b0) begin errors++; $display("FAIL disable_pending_clear got=%b want=0", pending[0]); end
      en[0] = 1'b1; step();
      capture(6);
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (cap_clk[0][k] !== ((k % 3) < 2)) begin
            errors++; $display("FAIL reenable_period cyc=%0d got=%b want=%b", k, cap_clk[0][k], (k % 3) < 2);
         end
      end
   endtask

   task automatic test_back_to_back();
      en[0] = 1'b0; step();
      en[0] = 1'b1; step();
      set_cfg(0, 5, 2); load[0] = 1'b1; step();
      set_cfg(0, 8, 3); step();
      load[0] = 1'b0; step();
      checks++;
      if (pending[0] !== 1'b0) begin errors++; $display("FAIL b2b_pending got=%b want=0", pending[0]); end
      capture(16);
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (cap_clk[0][k] !== ((k % 8) < 3)) begin
            errors++; $display("FAIL b2b_last_wins cyc=%0d got=%b want=%b", k, cap_clk[0][k], (k % 8) < 3);
         end
      end
      step(5);
      set_cfg(0, 5, 1); load[0] = 1'b1; step();
      load[0] = 1'b0; step();
      set_cfg(0, 4, 2); load[0] = 1'b1; step();
      load[0] = 1'b0;
      capture(5);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (cap_clk[0][k] !== (k < 1) || cap_pend[0][k] !== 1'b1) begin
            errors++; $display("FAIL wrap_load_old_applied cyc=%0d got=%b/%b want=%b/1", k,
                               cap_clk[0][k], cap_pend[0][k], k < 1);
         end
      end
      checks++;
      if (pending[0] !== 1'b0) begin errors++; $display("FAIL wrap_load_pending_clear got=%b want=0", pending[0]); end
      capture(8);
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (cap_clk[0][k] !== ((k % 4) < 2)) begin
            errors++; $display("FAIL wrap_load_new cyc=%0d got=%b want=%b", k, cap_clk[0][k], (k % 4) < 2);
         end
      end
   endtask

   task automatic test_independence_reset();
      en = '0; step();
      set_cfg(0, 3, 1); set_cfg(1, 7, 4);
      load = '1; step(); load = '0; step();
      en = '1; step();
      capture(21);
      for (int k = 0; k < 21; k++) begin
         checks++;
         if (cap_clk[0][k] !== ((k % 3) < 1) || cap_clk[1][k] !== ((k % 7) < 4)) begin
            errors++; $display("FAIL indep cyc=%0d got=%b%b want=%b%b", k, cap_clk[1][k], cap_clk[0][k],
                               (k % 7) < 4, (k % 3) < 1);
         end
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (clk_out !== '0 || tick !== '0 || pending !== '0) begin
         errors++; $display("FAIL async_reset got=%b/%b/%b want=00/00/00", clk_out, tick, pending);
      end
      step();
      reset = 1'b0;
      step();
      capture(20);
      for (int k = 0; k < 20; k++) begin
         for (int c = 0; c < CH; c++) begin
            checks++;
            if (cap_clk[c][k] !== ((k % 10) < 5) || cap_tick[c][k] !== ((k % 10) == 0)) begin
               errors++; $display("FAIL reset_defaults ch=%0d cyc=%0d got=%b/%b want=%b/%b", c, k,
                                  cap_clk[c][k], cap_tick[c][k], (k % 10) < 5, (k % 10) == 0);
            end
         end
      end
   endtask

   task automatic test_random();
      en = '0; load = '0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 800; i++) begin
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(0, 15) == 0) en[c] = ~en[c];
            load[c] = ($urandom_range(0, 7) == 0);
            set_cfg(c, ($urandom_range(0, 31) == 0) ? 65535 : int'($urandom_range(0, 12)),
                       ($urandom_range(0, 31) == 0) ? 65535 : int'($urandom_range(0, 14)));
         end
         step();
         for (int c = 0; c < CH; c++) begin
            checks++;
            if (clk_out[c] !== m_clk[c] || tick[c] !== m_tick[c] || pending[c] !== m_pend[c]) begin
               errors++; $display("FAIL random cyc=%0d ch=%0d got=%b%b%b want=%b%b%b", i, c,
                                  clk_out[c], tick[c], pending[c], m_clk[c], m_tick[c], m_pend[c]);
            end
         end
      end
      en = '0; load = '0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_defaults();
      test_boundary_apply();
      test_clamping();
      test_disable_reload();
      test_back_to_back();
      test_independence_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
